// File: rtl/cpu_pkg.sv
// Shared constants and the fetch state encoding for the 16-bit pipelined CPU.
package cpu_pkg;

  localparam int          INSTR_W   = 16;
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a returned instruction while decode stalls.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [15:0]        in_pc_plus2,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [15:0]        pc_plus2
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        pc2_q, pc2_d;

  // clear dominates load, load dominates drain
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc2_d   = in_pc_plus2;
    end else if (drain) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc_plus2 = pc2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, skid buffer and IF/ID register.
// Optional perf counters are enabled with the FETCH_PERF_EN macro.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [15:0]        if_id_pc_plus2,
  output logic               if_id_valid,
  output logic [4:0]         opcode,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        bubble_count
`endif
);

  fetch_state_e       state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic [15:0]        target_q, target_d;
  logic               req_en_q, req_en_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [15:0]        id_pc2_q, id_pc2_d;

  logic               skid_load_s, skid_drain_s, skid_clear_s;
  logic               skid_valid_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [15:0]        skid_pc2_s;
  logic               accept_s, fetch_ok_s;
  logic [15:0]        pc_plus2_s, redir_tgt_s;

  assign imem_req    = req_en_q && (state_q != ST_HALTED) && !skid_valid_s;
  assign imem_addr   = pc_q;
  assign accept_s    = imem_req && imem_ready;
  assign fetch_ok_s  = accept_s && (state_q == ST_FETCH) && !redirect;
  assign pc_plus2_s  = pc_q + 16'd2;
  assign redir_tgt_s = redirect_pc & 16'hFFFE;

  fetch_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .load        (skid_load_s),
    .drain       (skid_drain_s),
    .clear       (skid_clear_s),
    .in_instr    (imem_rdata),
    .in_pc_plus2 (pc_plus2_s),
    .valid       (skid_valid_s),
    .instr       (skid_instr_s),
    .pc_plus2    (skid_pc2_s)
  );

  // next state, PC and IF/ID; redirect overrides everything else
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    req_en_d     = 1'b1;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc2_d     = id_pc2_q;
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_clear_s = 1'b0;
    if (redirect) begin
      id_valid_d   = 1'b0;
      id_instr_d   = NOP_INSTR;
      id_pc2_d     = 16'h0000;
      skid_clear_s = 1'b1;
      // PC keeps the old address so imem_addr stays stable through SQUASH
      if (imem_req && !imem_ready) begin
        state_d  = ST_SQUASH;
        target_d = redir_tgt_s;
      end else begin
        state_d = ST_FETCH;
        pc_d    = redir_tgt_s;
      end
    end else begin
      if (!stall) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
        id_pc2_d   = 16'h0000;
      end else begin
        id_valid_d = id_valid_q;
      end
      case (state_q)
        ST_FETCH: begin
          if (accept_s) begin
            pc_d = pc_plus2_s;
            if (imem_rdata[15:11] == OP_HALT) begin
              state_d = ST_HALTED;
            end else begin
              state_d = ST_FETCH;
            end
            if (stall) begin
              skid_load_s = 1'b1;
            end else begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc2_d   = pc_plus2_s;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_SQUASH: begin
          if (accept_s) begin
            state_d = ST_FETCH;
            pc_d    = target_q;
          end else begin
            state_d = ST_SQUASH;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
      if (!stall && skid_valid_s) begin
        skid_drain_s = 1'b1;
        id_valid_d   = 1'b1;
        id_instr_d   = skid_instr_s;
        id_pc2_d     = skid_pc2_s;
      end else begin
        skid_drain_s = 1'b0;
      end
    end
  end

  // state, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      target_q   <= RESET_PC;
      req_en_q   <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc2_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      req_en_q   <= req_en_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc2_q   <= id_pc2_d;
    end
  end

  assign if_id_instr    = id_instr_q;
  assign if_id_pc_plus2 = id_pc2_q;
  assign if_id_valid    = id_valid_q;
  assign opcode         = id_instr_q[15:11];
  assign halted         = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // saturating counters
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_ok_s && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (!stall && !id_valid_d && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  logic unused_s;
  assign unused_s = fetch_ok_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors plus hand-written
// sequences for wait-state squash, HALT and (with FETCH_PERF_EN) the counters.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_ready;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_id_instr, if_id_pc_plus2;
  logic        if_id_valid, halted;
  logic [4:0]  opcode;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count, bubble_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] halt_addr = 16'hFFFF;
  int          wait_cfg  = 0;
  int          wcnt      = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid(if_id_valid), .opcode(opcode), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  // Memory: word at a is {5'b00010, a[11:1]}, or HALT at halt_addr; wait_cfg wait states.
  assign imem_ready = imem_req && (wcnt >= wait_cfg);
  always_comb begin
    if (imem_addr == halt_addr) imem_rdata = 16'h0000;
    else                        imem_rdata = {5'b00010, imem_addr[11:1]};
  end
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ready) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
  end

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        halted;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            stall redir rpc       req   addr      valid instr     pc2       halted
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h1000, 16'h0002, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1001, 16'h0004, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h1002, 16'h0006, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h1002, 16'h0006, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h1002, 16'h0006, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h1002, 16'h0006, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h1003, 16'h0008, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'h0101, 1'b1, 16'h000A, 1'b1, 16'h1004, 16'h000A, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0800, 16'h0000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b1, 16'h1080, 16'h0102, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0104, 1'b1, 16'h1080, 16'h0102, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0800, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h17FF, 16'h0000, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h1000, 16'h0002, 1'b0};

    // Table: sequential fetch, 3-cycle stall into skid, stall+redirect, skid clear, PC wrap.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      check($sformatf("v%0d req", i),    int'(imem_req),       int'(tbl[i].req));
      check($sformatf("v%0d addr", i),   int'(imem_addr),      int'(tbl[i].addr));
      check($sformatf("v%0d valid", i),  int'(if_id_valid),    int'(tbl[i].valid));
      check($sformatf("v%0d instr", i),  int'(if_id_instr),    int'(tbl[i].instr));
      check($sformatf("v%0d pc2", i),    int'(if_id_pc_plus2), int'(tbl[i].pc2));
      check($sformatf("v%0d opcode", i), int'(opcode),         int'(tbl[i].instr[15:11]));
      check($sformatf("v%0d halted", i), int'(halted),         int'(tbl[i].halted));
      step();
    end
    redirect = 1'b0; stall = 1'b0;

    // Two wait states, redirect to 0x0040 while the request to 0x0000 is pending.
    wait_cfg = 2;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1 check("sq req", int'(imem_req), 1);
    step();
    redirect = 1'b0;
    #1 check("sq hold addr1", int'(imem_addr), 16'h0000);
    check("sq valid1", int'(if_id_valid), 0);
    step();
    check("sq hold addr2", int'(imem_addr), 16'h0000);
    check("sq valid2", int'(if_id_valid), 0);
    step();
    check("sq new addr", int'(imem_addr), 16'h0040);
    check("sq valid3", int'(if_id_valid), 0);
    for (int k = 0; k < 10 && !if_id_valid; k++) step();
    check("sq first valid", int'(if_id_valid), 1);
    check("sq first instr", int'(if_id_instr), 16'h1020);
    check("sq first pc2", int'(if_id_pc_plus2), 16'h0042);

    // HALT at 0x0010, then redirect to 0x0020.
    wait_cfg = 0; halt_addr = 16'h0010;
    do_reset();
    for (int k = 0; k < 40 && !halted; k++) step();
    check("halt reached", int'(halted), 1);
    check("halt instr", int'(if_id_instr), 16'h0000);
    check("halt opcode", int'(opcode), int'(OP_HALT));
    check("halt pc2", int'(if_id_pc_plus2), 16'h0012);
    check("halt req", int'(imem_req), 0);
    step();
    check("halted req", int'(imem_req), 0);
    check("halted nop", int'(if_id_instr), int'(NOP_INSTR));
    check("halted nop opcode", int'(opcode), int'(OP_NOP));
    check("halted still", int'(halted), 1);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    #1 check("resume halted", int'(halted), 0);
    check("resume req", int'(imem_req), 1);
    check("resume addr", int'(imem_addr), 16'h0020);
    step();
    check("resume instr", int'(if_id_instr), 16'h1010);
    check("resume pc2", int'(if_id_pc_plus2), 16'h0022);
    halt_addr = 16'hFFFF;

`ifdef FETCH_PERF_EN
    // Ten accepted fetches, then a redirect whose same-cycle response is dropped.
    do_reset();
    check("perf reset fetch", int'(fetch_count), 0);
    check("perf reset bubble", int'(bubble_count), 0);
    for (int k = 0; k < 11; k++) step();
    redirect = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    #1 check("perf fetch_count", int'(fetch_count), 10);
    check("perf bubble nonzero", int'(bubble_count != 16'h0000), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit pipelined CPU. Holds the PC and issues requests to instruction memory through a req/ready handshake. Buffers one returned instruction when decode stalls, then loads the IF/ID pipeline register. Drives `opcode` (instr[15:11]) directly into the decode control unit, and handles redirects from execute and HALT detection.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold IF/ID contents.
- `redirect`  in  1  taken branch/jump resolved in execute.
- `redirect_pc`  in  16  target address; bit 0 is ignored and forced to 0.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  16  fetch address; held stable while `imem_req && !imem_ready`.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle; this completes the request.
- `imem_rdata`  in  16  fetched instruction.
- `if_id_instr`  out  16  IF/ID instruction; reads as NOP (16'h0800) when not valid.
- `if_id_pc_plus2`  out  16  address of the IF/ID instruction + 2.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `opcode`  out  5  `if_id_instr[15:11]`, combinational, feeds decode.
- `halted`  out  1  fetch stopped after a HALT.

## Operation
- **States:**
  - FETCH: request active, or issued next cycle.
  - SQUASH: an outstanding request is on the wrong path; its response is discarded.
  - HALTED: no requests are issued.
- **Request rule:** `imem_req`=1 in FETCH and SQUASH, but only while the skid buffer is empty.
- **Accept (FETCH, `imem_ready`):**
  - `pc <= pc+2`, wrapping mod 2^16 (16'hFFFE→16'h0000).
  - Instruction goes to IF/ID if `!stall`, otherwise to the skid buffer.
- **Skid drain:** when `!stall` and the skid is valid, IF/ID takes the skid entry and the skid clears. A new request issues the following cycle.
- **Stall:** IF/ID holds all fields. If the skid is empty, at most one response is absorbed into it.
- **Redirect:** overrides stall and every other event.
  - IF/ID is invalidated (NOP) and the skid is cleared.
  - `pc <= {redirect_pc[15:1],1'b0}`.
  - A response arriving in the same cycle is discarded.
  - If a request is outstanding and unanswered, go to SQUASH. Otherwise go to FETCH at the target.
- **SQUASH:** hold the old `imem_addr` until `imem_ready`, discard that response, then return to FETCH at the latched target. A further redirect while in SQUASH replaces the latched target.
- **HALT:** an accepted instruction with opcode 5'b00000 is loaded into IF/ID or the skid as normal. The state then moves to HALTED and `halted`=1.
- **Leaving HALTED:** only `redirect` (the HALT was on the wrong path) or `rst`.
- **NOP insertion:** when IF/ID is not loaded and not stalled, `if_id_valid`=0 and `if_id_instr`=16'h0800. Decode then sees the NOP opcode 5'b00001.

## Timing
- **Reset values:**
  - pc=`RESET_PC`, state=FETCH, skid empty.
  - `imem_req`=0 in the reset cycle, then 1.
  - `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=16'h0800, `if_id_pc_plus2`=0, `halted`=0.
  - Perf counters = 0.
- **Latency:** a response in cycle N appears in IF/ID at cycle N+1. With zero-wait memory, throughput is one instruction per cycle.
- **Redirect in cycle N:** `imem_addr`=target in cycle N+1, or after the squashed response. IF/ID is NOP at N+1.
- **Reset mid-request:** the response is dropped and the address restarts at `RESET_PC`. The memory must tolerate an abandoned request.

## Configuration
- `FETCH_PERF_EN` defined: adds output `fetch_count[15:0]` and output `bubble_count[15:0]`.
  - `fetch_count` counts accepted non-squashed responses.
  - `bubble_count` counts cycles with `!stall && !if_id_valid` next.
  - Both counters saturate at 16'hFFFF.
- Not defined: the ports and counters are absent.

## Structure
- **Package `cpu_pkg`:** `OP_HALT`=5'b00000, `OP_NOP`=5'b00001, `NOP_INSTR`=16'h0800, `INSTR_W`=16, and the fetch state enum.
- **Sub-module `fetch_skid`:** one-entry buffer (valid, instr, pc_plus2) with load/drain/clear inputs.

## Test plan
- Zero-wait memory, sequential code from 0: instructions at 0, 2, 4 appear in consecutive cycles; `if_id_pc_plus2` = 2, 4, 6.
- Memory with 2-cycle wait, redirect to 16'h0040 during the wait: the old address is held until ready; the response is discarded; next `imem_addr`=16'h0040; IF/ID stays NOP.
- Stall asserted for 3 cycles as a response arrives: the response goes to the skid, no new request issues, IF/ID is unchanged; after release the skid instruction enters IF/ID, then fetch resumes.
- HALT (16'h0000) fetched at 16'h0010: it enters IF/ID, `halted`=1, `imem_req`=0 thereafter; a redirect to 16'h0020 resumes fetch.
- Stall and redirect in the same cycle: redirect wins, IF/ID=NOP, skid cleared, PC=target. Also check that `pc` at 16'hFFFE wraps to 16'h0000.
- With `FETCH_PERF_EN`: 10 sequential fetches plus 1 redirect gives `fetch_count`=10 and `bubble_count`≥1.
